// File: rtl/muldiv_if.sv
// Issue/result handshake bundle between the execute stage and the iterative
// multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_func;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_func, in_a, in_b, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_func, in_a, in_b, in_tag, flush, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on magnitudes, one bit per cycle, sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_nx;
  logic [2:0]        func_q;
  logic [TAG_W-1:0]  tag_q;
  logic [XLEN-1:0]   opd_q;
  logic [2*XLEN-1:0] acc_q;
  logic              neg_res_q, neg_rem_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   result_q;

  logic              is_div, sgn_a, sgn_b, a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, accept;
  logic [XLEN-1:0]   special_res;

  always_comb begin
    is_div   = bus.in_func[2];
    sgn_a    = (bus.in_func == 3'd1) || (bus.in_func == 3'd2) ||
               (bus.in_func == 3'd4) || (bus.in_func == 3'd6);
    sgn_b    = (bus.in_func == 3'd1) || (bus.in_func == 3'd4) ||
               (bus.in_func == 3'd6);
    a_neg    = sgn_a & bus.in_a[XLEN-1];
    b_neg    = sgn_b & bus.in_b[XLEN-1];
    mag_a    = a_neg ? -bus.in_a : bus.in_a;
    mag_b    = b_neg ? -bus.in_b : bus.in_b;
    div_zero = is_div && (bus.in_b == '0);
    div_ovf  = is_div && !bus.in_func[0] &&
               (bus.in_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.in_b == '1);
    if (div_zero) special_res = bus.in_func[1] ? bus.in_a : '1;
    else          special_res = bus.in_func[1] ? '0 : bus.in_a;
    accept   = (state == IDLE) && bus.in_valid && !bus.flush;
  end

  // One iteration: multiply keeps {partial sum, remaining multiplier},
  // divide keeps {partial remainder, dividend/quotient shift register}.
  logic [XLEN:0]     mul_sum, div_part, div_diff;
  logic [2*XLEN-1:0] step_nx, prod_fix;
  logic [XLEN-1:0]   quo, rem, fix_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    div_part = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_part - {1'b0, opd_q};
    if (!func_q[2])      step_nx = {mul_sum, acc_q[XLEN-1:1]};
    else if (div_diff[XLEN]) step_nx = {div_part[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else                 step_nx = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo      = acc_q[XLEN-1:0];
    rem      = acc_q[2*XLEN-1:XLEN];
    if (!func_q[2])      fix_res = (func_q == 3'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else if (func_q[1])  fix_res = neg_rem_q ? -rem : rem;
    else                 fix_res = neg_res_q ? -quo : quo;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = (div_zero || div_ovf) ? DONE : CALC;
      CALC: if (cnt_q == CW'(XLEN-1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_q    <= '0;
      tag_q     <= '0;
      opd_q     <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else if (accept) begin
      func_q    <= bus.in_func;
      tag_q     <= bus.in_tag;
      opd_q     <= is_div ? mag_b : mag_a;
      acc_q     <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      cnt_q     <= '0;
      if (div_zero || div_ovf) result_q <= special_res;
    end else if (state == CALC) begin
      acc_q <= step_nx;
      cnt_q <= cnt_q + CW'(1);
    end else if (state == FIX) begin
      result_q <= fix_res;
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.out_result = result_q;
  assign bus.out_tag    = tag_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32 plus an XLEN=8 instance checked
// against behavioural integer arithmetic.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32), .TAG_W(5)) b32 ();
  muldiv_if #(.XLEN(8),  .TAG_W(5)) b8 ();

  muldiv_unit #(.XLEN(32), .TAG_W(5)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  muldiv_unit #(.XLEN(8),  .TAG_W(5)) u8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  task automatic op32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] t, input bit hold,
                      output logic [31:0] res, output logic [4:0] tg, output int lat);
    b32.in_func = f; b32.in_a = a; b32.in_b = b; b32.in_tag = t; b32.in_valid = 1'b1;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    lat = 1;
    while (!b32.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!b32.out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL op32_timeout: out_valid=0 after %0d cycles, required 1", lat);
    end
    res = b32.out_result;
    tg  = b32.out_tag;
    if (!hold) begin
      b32.out_ready = 1'b1;
      @(posedge clk); #1;
      b32.out_ready = 1'b0;
    end
  endtask

  task automatic op8(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                     output logic [7:0] res, output int lat);
    b8.in_func = f; b8.in_a = a; b8.in_b = b; b8.in_tag = 5'd3; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    lat = 1;
    while (!b8.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!b8.out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL op8_timeout: out_valid=0 after %0d cycles, required 1", lat);
    end
    res = b8.out_result;
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
  endtask

  function automatic logic [7:0] ref8(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, ua, ub, p;
    sa = int'($signed(a)); sb = int'($signed(b));
    ua = int'(a);          ub = int'(b);
    case (f)
      3'd0: p = sa * sb;
      3'd1: p = (sa * sb) >>> 8;
      3'd2: p = (sa * ub) >>> 8;
      3'd3: p = (ua * ub) >>> 8;
      3'd4: p = (ub == 0) ? -1 : (a == 8'h80 && b == 8'hFF) ? sa : sa / sb;
      3'd5: p = (ub == 0) ? -1 : ua / ub;
      3'd6: p = (ub == 0) ? sa : (a == 8'h80 && b == 8'hFF) ? 0 : sa % sb;
      default: p = (ub == 0) ? ua : ua % ub;
    endcase
    return p[7:0];
  endfunction

  task automatic test_reset();
    n_checks++; if (b32.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", b32.out_valid); end
    n_checks++; if (b32.out_result !== 32'h0) begin n_fail++; $display("FAIL reset_out_result: got %h, required 0", b32.out_result); end
    n_checks++; if (b32.out_tag !== 5'h0) begin n_fail++; $display("FAIL reset_out_tag: got %h, required 0", b32.out_tag); end
    n_checks++; if (b32.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", b32.in_ready); end
  endtask

  task automatic test_mul();
    logic [31:0] r; logic [4:0] tg; int lat;
    op32(3'd0, 32'd7, 32'hFFFFFFFD, 5'd17, 1'b0, r, tg, lat);
    n_checks++; if (r !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_result: got %h, required ffffffeb", r); end
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL mul_latency: got %0d, required 34", lat); end
    n_checks++; if (tg !== 5'd17) begin n_fail++; $display("FAIL mul_tag: got %0d, required 17", tg); end
    op32(3'd1, 32'h80000000, 32'h80000000, 5'd1, 1'b0, r, tg, lat);
    n_checks++; if (r !== 32'h40000000) begin n_fail++; $display("FAIL mulh_result: got %h, required 40000000", r); end
    op32(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 1'b0, r, tg, lat);
    n_checks++; if (r !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mulhu_result: got %h, required fffffffe", r); end
    op32(3'd2, 32'hFFFFFFFF, 32'd2, 5'd3, 1'b0, r, tg, lat);
    n_checks++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulhsu_result: got %h, required ffffffff", r); end
  endtask

  task automatic test_div();
    logic [31:0] r; logic [4:0] tg; int lat;
    op32(3'd4, 32'hFFFFFFF9, 32'd2, 5'd4, 1'b0, r, tg, lat);
    n_checks++; if (r !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_result: got %h, required fffffffd", r); end
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL div_latency: got %0d, required 34", lat); end
    op32(3'd6, 32'hFFFFFFF9, 32'd2, 5'd5, 1'b0, r, tg, lat);
    n_checks++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL rem_result: got %h, required ffffffff", r); end
    op32(3'd5, 32'd100, 32'd7, 5'd6, 1'b0, r, tg, lat);
    n_checks++; if (r !== 32'd14) begin n_fail++; $display("FAIL divu_result: got %0d, required 14", r); end
    op32(3'd7, 32'd100, 32'd7, 5'd7, 1'b0, r, tg, lat);
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL remu_result: got %0d, required 2", r); end
  endtask

  task automatic test_special();
    logic [31:0] r; logic [4:0] tg; int lat;
    op32(3'd4, 32'd5, 32'd0, 5'd8, 1'b0, r, tg, lat);
    n_checks++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div0_result: got %h, required ffffffff", r); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL div0_latency: got %0d, required 1", lat); end
    n_checks++; if (tg !== 5'd8) begin n_fail++; $display("FAIL div0_tag: got %0d, required 8", tg); end
    op32(3'd7, 32'd5, 32'd0, 5'd9, 1'b0, r, tg, lat);
    n_checks++; if (r !== 32'd5) begin n_fail++; $display("FAIL remu0_result: got %h, required 5", r); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL remu0_latency: got %0d, required 1", lat); end
    op32(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd10, 1'b0, r, tg, lat);
    n_checks++; if (r !== 32'h80000000) begin n_fail++; $display("FAIL divovf_result: got %h, required 80000000", r); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL divovf_latency: got %0d, required 1", lat); end
    op32(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd11, 1'b0, r, tg, lat);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL removf_result: got %h, required 0", r); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL removf_latency: got %0d, required 1", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; logic [4:0] tg; int lat;
    op32(3'd5, 32'd100, 32'd7, 5'd9, 1'b1, r, tg, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (b32.out_valid !== 1'b1 || b32.out_result !== 32'd14 || b32.out_tag !== 5'd9 || b32.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: valid=%b result=%h tag=%0d in_ready=%b, required 1/0000000e/9/0",
                 i, b32.out_valid, b32.out_result, b32.out_tag, b32.in_ready);
      end
    end
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.out_ready = 1'b0;
    n_checks++; if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_idle: valid=%b in_ready=%b, required 0/1", b32.out_valid, b32.in_ready); end
    op32(3'd7, 32'd100, 32'd7, 5'd12, 1'b0, r, tg, lat);
    n_checks++; if (r !== 32'd2 || lat !== 34 || tg !== 5'd12) begin n_fail++; $display("FAIL after_release_op: result=%0d lat=%0d tag=%0d, required 2/34/12", r, lat, tg); end
  endtask

  task automatic test_flush();
    int seen;
    b32.in_func = 3'd0; b32.in_a = 32'd3; b32.in_b = 32'd4; b32.in_tag = 5'd13;
    b32.in_valid = 1'b1; b32.flush = 1'b1;
    @(posedge clk); #1;
    b32.in_valid = 1'b0; b32.flush = 1'b0;
    n_checks++; if (b32.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_beats_valid: in_ready=%b, required 1", b32.in_ready); end
    b32.in_valid = 1'b1;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    n_checks++; if (b32.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_accept: in_ready=%b, required 0", b32.in_ready); end
    repeat (4) @(posedge clk);
    #1 b32.flush = 1'b1;
    @(posedge clk); #1;
    b32.flush = 1'b0;
    n_checks++; if (b32.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b, required 1", b32.in_ready); end
    seen = 0;
    b32.out_ready = 1'b1;
    repeat (40) begin
      if (b32.out_valid) seen++;
      @(posedge clk); #1;
    end
    b32.out_ready = 1'b0;
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_output: out_valid seen %0d cycles, required 0", seen); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic [4:0] tg; int lat;
    op32(3'd5, 32'd100, 32'd7, 5'd21, 1'b0, r, tg, lat);
    b32.in_func = 3'd0; b32.in_a = 32'd9; b32.in_b = 32'd9; b32.in_tag = 5'd22; b32.in_valid = 1'b1;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (b32.out_valid !== 1'b0 || b32.out_result !== 32'h0 || b32.out_tag !== 5'h0 || b32.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b result=%h tag=%0d in_ready=%b, required 0/0/0/1",
               b32.out_valid, b32.out_result, b32.out_tag, b32.in_ready);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    b32.out_ready = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      n_checks++; if (b32.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_no_output: out_valid=%b, required 0", b32.out_valid); end
    end
    b32.out_ready = 1'b0;
  endtask

  task automatic test_xlen8();
    logic [7:0] r, a, b, exp; int lat;
    logic [7:0] va [6];
    logic [7:0] vb [6];
    op8(3'd0, 8'd7, 8'hFD, r, lat);
    n_checks++; if (r !== 8'hEB || lat !== 10) begin n_fail++; $display("FAIL x8_mul_latency: result=%h lat=%0d, required eb/10", r, lat); end
    for (int f = 0; f < 8; f++) begin
      va[0] = 8'h80; vb[0] = 8'hFF;
      va[1] = 8'h85; vb[1] = 8'h00;
      va[2] = 8'hFF; vb[2] = 8'hFF;
      for (int k = 3; k < 6; k++) begin
        va[k] = 8'($urandom_range(255));
        vb[k] = 8'($urandom_range(255));
      end
      for (int k = 0; k < 6; k++) begin
        a = va[k]; b = vb[k];
        exp = ref8(3'(f), a, b);
        op8(3'(f), a, b, r, lat);
        n_checks++;
        if (r !== exp) begin
          n_fail++;
          $display("FAIL x8_func%0d a=%h b=%h: got %h, required %h", f, a, b, r, exp);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    b32.in_valid = 1'b0; b32.in_func = '0; b32.in_a = '0; b32.in_b = '0; b32.in_tag = '0;
    b32.flush = 1'b0; b32.out_ready = 1'b0;
    b8.in_valid = 1'b0; b8.in_func = '0; b8.in_a = '0; b8.in_b = '0; b8.in_tag = '0;
    b8.flush = 1'b0; b8.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_xlen8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide execution unit covering the full RV32M operation set.
- Sits beside the single-cycle ALU in the execute stage; the decoder issues M-extension ops to it over a valid/ready handshake, and the pipeline stalls until the result returns.
- Parametrised in datapath width. Carries a destination-register tag so writeback needs no external bookkeeping.

Parameters:
XLEN, 32, operand/result width in bits (any even value >= 8)
TAG_W, 5, width of the destination tag carried alongside the operation

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  unit can accept a request (high only in IDLE)
in_func  in  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
in_a  in  XLEN  rs1 operand
in_b  in  XLEN  rs2 operand
in_tag  in  TAG_W  destination tag
flush  in  1  synchronous abort of any in-flight operation
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_result  out  XLEN  result
out_tag  out  TAG_W  tag of the operation producing out_result

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; out_valid=0; out_result=0; out_tag=0; in_ready=1 once reset is released; all internal registers cleared.
- Reset mid-operation discards the operation; no output is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge, latch func, tag, operand magnitudes and the result-sign/operand-sign flags.
  - Signedness: MULH, DIV and REM treat both operands as signed. MULHSU treats a as signed and b as unsigned. MUL, MULHU, DIVU and REMU take magnitudes as given (MUL low half is sign-agnostic).
  - Normal ops go to CALC with counter=0.
  - Special cases go directly to DONE with the result computed at this edge:
    - divide by zero (in_b==0, func 4-7): DIV/DIVU quotient = all ones; REM/REMU = in_a.
    - signed overflow (DIV/REM, in_a = most negative, in_b = all ones): DIV = in_a; REM = 0.
- CALC:
  - Exactly XLEN cycles, one bit per cycle; counter increments 0..XLEN-1. Leave to FIX when counter==XLEN-1.
  - Multiply: shift-add over a 2*XLEN product register.
  - Divide: restoring divide producing XLEN-bit quotient and remainder.
- FIX (1 cycle):
  - Apply sign correction by two's-complement negation.
  - Product is negated when operand signs differ (signed ops).
  - Quotient is negated when signs differ; remainder takes the dividend's sign.
  - Select the low or high product half, quotient or remainder. Then go to DONE.
- DONE:
  - out_valid=1; out_result and out_tag stable until the handshake.
  - On out_ready, go to IDLE with out_valid=0 next cycle.
  - No new request is accepted in the handshake cycle (in_ready=0 in DONE).
- Latency:
  - Normal ops: out_valid rises XLEN+2 edges after the accepting edge (XLEN CALC + FIX + entry to DONE).
  - Special cases: out_valid rises 1 edge after acceptance.
  - Throughput: at most one op per XLEN+3 cycles with out_ready held high.
- flush:
  - From any state, go to IDLE at the next edge; out_valid=0 next cycle; the result is discarded.
  - flush beats in_valid in the same cycle (request not accepted), and beats out_ready in DONE (treated as discard; same visible effect).
- Arithmetic is modulo 2^XLEN for all outputs; all internal widths derive from XLEN; no hard-coded 32.
- out_result holds its last value when out_valid=0 (don't-care for checking).

Test Plan:
- XLEN=32, MUL a=7, b=0xFFFFFFFD (-3) -> out_result=0xFFFFFFEB, out_valid exactly 34 cycles after acceptance, out_tag equals in_tag.
- MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU same -> 2.
- Special cases, each with out_valid 1 cycle after acceptance:
  - DIV a=5, b=0 -> 0xFFFFFFFF; REMU a=5, b=0 -> 5.
  - DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Back-pressure and flush:
  - out_ready held 0 for 10 cycles in DONE -> out_valid, out_result and out_tag stable, in_ready=0; release -> IDLE and new op accepted the following cycle.
  - flush in cycle 5 of CALC -> out_valid never asserts, in_ready=1 next cycle.
  - rst_n pulsed low mid-CALC -> outputs cleared immediately.
- XLEN=8 build, random signed/unsigned operands for all 8 funcs against a reference model -> all match; MUL latency = 10 cycles.
